// File: rtl/ren_free_list_pkg.sv
// Shared constants for the rename free list.
// Holds the riscv-level sizing constants (default physical register file
// size, its address width, XLEN, architectural register index width) and a
// small helper that counts set bits in a pair of per-slot flags.
package ren_free_list_pkg;

   localparam int XLEN                    = 64;
   localparam int DEF_NB_PHYS_REGS        = 64;
   localparam int DEF_PHYS_REGS_ADDR_SIZE = $clog2(DEF_NB_PHYS_REGS);
   localparam int ARCH_REG_W              = 5;

   // Number of set flags among two slots (0, 1 or 2)
   function automatic logic [1:0] cnt2(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

// File: rtl/ren_fl_fifo.sv
// Circular free-list storage: two read ports at the speculative head, two
// write ports at the tail, plus a retire head that the speculative head
// rolls back to on flush. Pointers carry one extra wrap bit, so the free
// count is a plain subtraction.
module ren_fl_fifo
   import ren_free_list_pkg::*;
#(
   parameter int NB = DEF_NB_PHYS_REGS,
   parameter int AW = $clog2(NB)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [1:0]    alloc_cnt_i,
   input  logic [1:0]    ret_cnt_i,
   input  logic          flush_i,
   input  logic          push0_v_i,
   input  logic [AW-1:0] push0_phys_i,
   input  logic          push1_v_i,
   input  logic [AW-1:0] push1_phys_i,
   output logic [AW-1:0] rd0_phys_o,
   output logic [AW-1:0] rd1_phys_o,
   output logic [AW:0]   free_count_o
);

   typedef logic [AW:0] fl_ptr_t;

   logic [AW-1:0] mem_q [NB];
   fl_ptr_t       spec_head_q, spec_head_d;
   fl_ptr_t       ret_head_q, ret_head_d;
   fl_ptr_t       tail_q, tail_d;
   fl_ptr_t       occ_d;
   logic [1:0]    push_cnt;
   logic [AW-1:0] sh_idx0, sh_idx1;
   logic [AW-1:0] tl_idx0, tl_idx1;
   logic          wr0_en, wr1_en;
   logic [AW-1:0] wr0_data;

   assign sh_idx0 = spec_head_q[AW-1:0];
   assign sh_idx1 = spec_head_q[AW-1:0] + AW'(1);
   assign tl_idx0 = tail_q[AW-1:0];
   assign tl_idx1 = tail_q[AW-1:0] + AW'(1);

   assign rd0_phys_o   = mem_q[sh_idx0];
   assign rd1_phys_o   = mem_q[sh_idx1];
   assign free_count_o = tail_q - spec_head_q;

   // Pushes are packed: a lone slot-1 push lands at the tail itself
   assign push_cnt = cnt2(push0_v_i, push1_v_i);
   assign wr0_en   = push0_v_i | push1_v_i;
   assign wr1_en   = push0_v_i & push1_v_i;
   assign wr0_data = push0_v_i ? push0_phys_i : push1_phys_i;

   // Next pointers; flush rewinds the speculative head to the post-commit retire head
   always_comb begin
      ret_head_d  = ret_head_q + fl_ptr_t'(ret_cnt_i);
      tail_d      = tail_q + fl_ptr_t'(push_cnt);
      spec_head_d = spec_head_q + fl_ptr_t'(alloc_cnt_i);
      if (flush_i) begin
         spec_head_d = ret_head_d;
      end
   end

   // Pointer registers; reset leaves NB-1 registers free (phys 0 is never listed)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         spec_head_q <= '0;
         ret_head_q  <= '0;
         tail_q      <= fl_ptr_t'(NB - 1);
      end else begin
         spec_head_q <= spec_head_d;
         ret_head_q  <= ret_head_d;
         tail_q      <= tail_d;
      end
   end

   // Storage; entry i resets to i+1, the last entry wraps to 0 by truncation
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NB; i++) begin
            mem_q[i] <= AW'(i + 1);
         end
      end else begin
         if (wr0_en) begin
            mem_q[tl_idx0] <= wr0_data;
         end
         if (wr1_en) begin
            mem_q[tl_idx1] <= push1_phys_i;
         end
      end
   end

   // Entries between retire head and tail are distinct non-zero registers,
   // so that span can never exceed NB-1; a larger span means a double free.
   assign occ_d = tail_d - ret_head_d;

   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      occ_d <= fl_ptr_t'(NB - 1));

endmodule

// File: rtl/ren_free_list.sv
// Rename free-list controller: allocates up to two physical registers per
// cycle (all-or-nothing), drives the rename table write ports, returns
// superseded mappings at commit and rolls back speculation on flush.
// Optional build macro REN_STALL_CNT_EN adds a saturating 32-bit stall_cnt
// output counting cycles where slot 0 is presented but not accepted.
module ren_free_list
   import ren_free_list_pkg::*;
#(
   parameter  int NB_PHYS_REGS        = DEF_NB_PHYS_REGS,
   localparam int PHYS_REGS_ADDR_SIZE = $clog2(NB_PHYS_REGS)
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           dec_instr0_v,
   input  logic                           dec_instr0_v_rd,
   input  logic [ARCH_REG_W-1:0]          dec_instr0_rd,
   input  logic                           dec_instr1_v,
   input  logic                           dec_instr1_v_rd,
   input  logic [ARCH_REG_W-1:0]          dec_instr1_rd,
   output logic                           ren_ready,
   output logic                           instr0_v_rd,
   output logic [PHYS_REGS_ADDR_SIZE-1:0] instr0_phys_rd,
   output logic [ARCH_REG_W-1:0]          instr0_rd,
   output logic                           instr1_v_rd,
   output logic [PHYS_REGS_ADDR_SIZE-1:0] instr1_phys_rd,
   output logic [ARCH_REG_W-1:0]          instr1_rd,
   input  logic                           commit0_v,
   input  logic                           commit0_v_rd,
   input  logic [PHYS_REGS_ADDR_SIZE-1:0] commit0_old_phys,
   input  logic                           commit1_v,
   input  logic                           commit1_v_rd,
   input  logic [PHYS_REGS_ADDR_SIZE-1:0] commit1_old_phys,
   input  logic                           flush,
   output logic [PHYS_REGS_ADDR_SIZE:0]   free_count
`ifdef REN_STALL_CNT_EN
   ,output logic [31:0]                   stall_cnt
`endif
);

   localparam int AW = PHYS_REGS_ADDR_SIZE;

   logic          need0, need1;
   logic [1:0]    needs;
   logic [1:0]    alloc_cnt;
   logic [1:0]    ret_cnt;
   logic          cmt0_rd, cmt1_rd;
   logic          push0_v, push1_v;
   logic [AW-1:0] head0_phys, head1_phys;

   // x0 destinations never take a physical register
   assign need0 = dec_instr0_v & dec_instr0_v_rd & (dec_instr0_rd != '0);
   assign need1 = dec_instr1_v & dec_instr1_v_rd & (dec_instr1_rd != '0);
   assign needs = cnt2(need0, need1);

   assign ren_ready = ~flush & (free_count >= (AW + 1)'(needs));
   assign alloc_cnt = ren_ready ? needs : 2'd0;

   assign instr0_v_rd    = need0 & ren_ready;
   assign instr1_v_rd    = need1 & ren_ready;
   assign instr0_phys_rd = instr0_v_rd ? head0_phys : '0;
   // Slot 1 takes the second entry only when slot 0 consumed the first
   assign instr1_phys_rd = instr1_v_rd ? (need0 ? head1_phys : head0_phys) : '0;
   assign instr0_rd      = dec_instr0_rd;
   assign instr1_rd      = dec_instr1_rd;

   // Every retiring writer advances the retire head; only non-zero old mappings are freed
   assign cmt0_rd = commit0_v & commit0_v_rd;
   assign cmt1_rd = commit1_v & commit1_v_rd;
   assign ret_cnt = cnt2(cmt0_rd, cmt1_rd);
   assign push0_v = cmt0_rd & (commit0_old_phys != '0);
   assign push1_v = cmt1_rd & (commit1_old_phys != '0);

   ren_fl_fifo #(
      .NB (NB_PHYS_REGS),
      .AW (AW)
   ) u_fifo (
      .clk          (clk),
      .resetn       (resetn),
      .alloc_cnt_i  (alloc_cnt),
      .ret_cnt_i    (ret_cnt),
      .flush_i      (flush),
      .push0_v_i    (push0_v),
      .push0_phys_i (commit0_old_phys),
      .push1_v_i    (push1_v),
      .push1_phys_i (commit1_old_phys),
      .rd0_phys_o   (head0_phys),
      .rd1_phys_o   (head1_phys),
      .free_count_o (free_count)
   );

`ifdef REN_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Count rename back-pressure cycles; flush cycles are not stalls
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (dec_instr0_v & ~ren_ready & ~flush & (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ren_free_list.sv
// Scoreboard bench for ren_free_list (NB_PHYS_REGS = 64). The driver issues
// one cycle of stimulus at a time and queues the expected outputs; a monitor
// on the falling edge pops and compares. Build with +define+REN_STALL_CNT_EN
// to also check the stall counter.
module tb_ren_free_list;

   logic       clk = 1'b0;
   logic       resetn;
   logic       dec_instr0_v, dec_instr0_v_rd, dec_instr1_v, dec_instr1_v_rd;
   logic [4:0] dec_instr0_rd, dec_instr1_rd;
   logic       ren_ready, instr0_v_rd, instr1_v_rd;
   logic [5:0] instr0_phys_rd, instr1_phys_rd;
   logic [4:0] instr0_rd, instr1_rd;
   logic       commit0_v, commit0_v_rd, commit1_v, commit1_v_rd;
   logic [5:0] commit0_old_phys, commit1_old_phys;
   logic       flush;
   logic [6:0] free_count;
`ifdef REN_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   typedef struct {
      string       name;
      logic        chk_rdy;
      logic        rdy;
      logic        v0;
      logic        v1;
      logic [5:0]  p0;
      logic [5:0]  p1;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [6:0]  fc;
      logic [31:0] sc;
   } exp_t;

   exp_t q[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   exp_stall = 0;

   always #5 clk = ~clk;

   ren_free_list dut (
      .clk              (clk),
      .resetn           (resetn),
      .dec_instr0_v     (dec_instr0_v),
      .dec_instr0_v_rd  (dec_instr0_v_rd),
      .dec_instr0_rd    (dec_instr0_rd),
      .dec_instr1_v     (dec_instr1_v),
      .dec_instr1_v_rd  (dec_instr1_v_rd),
      .dec_instr1_rd    (dec_instr1_rd),
      .ren_ready        (ren_ready),
      .instr0_v_rd      (instr0_v_rd),
      .instr0_phys_rd   (instr0_phys_rd),
      .instr0_rd        (instr0_rd),
      .instr1_v_rd      (instr1_v_rd),
      .instr1_phys_rd   (instr1_phys_rd),
      .instr1_rd        (instr1_rd),
      .commit0_v        (commit0_v),
      .commit0_v_rd     (commit0_v_rd),
      .commit0_old_phys (commit0_old_phys),
      .commit1_v        (commit1_v),
      .commit1_v_rd     (commit1_v_rd),
      .commit1_old_phys (commit1_old_phys),
      .flush            (flush),
      .free_count       (free_count)
`ifdef REN_STALL_CNT_EN
      ,.stall_cnt       (stall_cnt)
`endif
   );

   // Monitor: compare whatever the driver queued for this cycle
   always @(negedge clk) begin
      exp_t e;
      logic ok;
      if (q.size() != 0) begin
         e  = q.pop_front();
         ok = (!e.chk_rdy || (ren_ready === e.rdy)) &&
              (instr0_v_rd === e.v0) && (instr1_v_rd === e.v1) &&
              (instr0_phys_rd === e.p0) && (instr1_phys_rd === e.p1) &&
              (instr0_rd === e.r0) && (instr1_rd === e.r1) &&
              (free_count === e.fc);
`ifdef REN_STALL_CNT_EN
         if (stall_cnt !== e.sc) begin
            ok = 1'b0;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
         end
`endif
         n_checks++;
         if (ok) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got rdy=%0b v=%0b/%0b phys=%0d/%0d rd=%0d/%0d fc=%0d, expected rdy=%0b v=%0b/%0b phys=%0d/%0d rd=%0d/%0d fc=%0d",
                     e.name, ren_ready, instr0_v_rd, instr1_v_rd, instr0_phys_rd, instr1_phys_rd,
                     instr0_rd, instr1_rd, free_count,
                     e.rdy, e.v0, e.v1, e.p0, e.p1, e.r0, e.r1, e.fc);
         end
      end
   end

   task automatic idle();
      dec_instr0_v = 0; dec_instr0_v_rd = 0; dec_instr0_rd = '0;
      dec_instr1_v = 0; dec_instr1_v_rd = 0; dec_instr1_rd = '0;
      commit0_v = 0; commit0_v_rd = 0; commit0_old_phys = '0;
      commit1_v = 0; commit1_v_rd = 0; commit1_old_phys = '0;
      flush = 0;
   endtask

   task automatic dec(input bit v0, input bit vrd0, input int rd0,
                      input bit v1, input bit vrd1, input int rd1);
      dec_instr0_v = v0; dec_instr0_v_rd = vrd0; dec_instr0_rd = 5'(rd0);
      dec_instr1_v = v1; dec_instr1_v_rd = vrd1; dec_instr1_rd = 5'(rd1);
   endtask

   task automatic cmt(input bit v0, input bit vrd0, input int old0,
                      input bit v1, input bit vrd1, input int old1);
      commit0_v = v0; commit0_v_rd = vrd0; commit0_old_phys = 6'(old0);
      commit1_v = v1; commit1_v_rd = vrd1; commit1_old_phys = 6'(old1);
   endtask

   // One clock of stimulus with its expected outputs
   task automatic cyc(input string name, input bit rdy, input bit v0, input int p0,
                      input bit v1, input int p1, input int fc);
      exp_t e;
      e.name = name; e.chk_rdy = 1'b1; e.rdy = rdy;
      e.v0 = v0; e.p0 = 6'(p0); e.v1 = v1; e.p1 = 6'(p1);
      e.r0 = dec_instr0_rd; e.r1 = dec_instr1_rd;
      e.fc = 7'(fc); e.sc = 32'(exp_stall);
      q.push_back(e);
      if (dec_instr0_v && !rdy && !flush) exp_stall++;
      @(posedge clk); #1;
      idle();
   endtask

   // Assert reset for one cycle; the state must be reset before any clock edge
   task automatic rst_cyc(input string name);
      exp_t e;
      resetn = 1'b0;
      e.name = name; e.chk_rdy = 1'b0; e.rdy = 1'b0;
      e.v0 = 1'b0; e.p0 = '0; e.v1 = 1'b0; e.p1 = '0;
      e.r0 = dec_instr0_rd; e.r1 = dec_instr1_rd;
      e.fc = 7'd63; e.sc = '0;
      q.push_back(e);
      exp_stall = 0;
      @(posedge clk); #1;
      resetn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      idle();
      @(posedge clk); #1;
      rst_cyc("reset");

      // Basic allocation
      dec(1,1,5, 0,0,0); cyc("first_alloc",    1, 1,1, 0,0, 63);
      cyc("fc_after_alloc", 1, 0,0, 0,0, 62);
      rst_cyc("mid_reset");
      dec(1,1,3, 1,1,7); cyc("dual",           1, 1,1, 1,2, 63);
      dec(1,1,0, 1,1,7); cyc("slot0_rd0",      1, 0,0, 1,3, 61);
      dec(1,0,4, 1,1,8); cyc("slot0_novrd",    1, 0,0, 1,4, 60);

      // Exhaustion
      rst_cyc("reset2");
      for (int k = 0; k < 31; k++) begin
         dec(1,1,10, 1,1,11);
         cyc($sformatf("drain%0d", k), 1, 1, 2*k+1, 1, 2*k+2, 63 - 2*k);
      end
      dec(1,1,10, 1,1,11); cyc("dual_at1",     0, 0,0, 0,0, 1);
      dec(1,1,9, 0,0,0);   cyc("single_at1",   1, 1,63, 0,0, 1);
      dec(1,1,9, 0,0,0);   cyc("single_at0",   0, 0,0, 0,0, 0);
      dec(1,1,0, 0,0,0);   cyc("noneed_at0",   1, 0,0, 0,0, 0);
      for (int k = 0; k < 8; k++) begin
         dec(1,1,9, 0,0,0);
         cyc($sformatf("stall%0d", k), 0, 0,0, 0,0, 0);
      end
      cyc("stall_total", 1, 0,0, 0,0, 0);

      // Commit frees: no same-cycle bypass, then reuse and pointer wrap
      dec(1,1,9, 0,0,0); cmt(1,1,9, 1,1,0);
      cyc("commit_no_bypass", 0, 0,0, 0,0, 0);
      dec(1,1,4, 0,0,0); cyc("realloc9",       1, 1,9, 0,0, 1);
      cmt(1,1,12, 1,1,13); cyc("commit_pair",  1, 0,0, 0,0, 0);
      cmt(1,1,0, 1,1,15);  cyc("commit_slot1", 1, 0,0, 0,0, 2);
      dec(1,1,4, 1,1,5); cyc("wrap_dual",      1, 1,12, 1,13, 3);
      dec(1,1,6, 0,0,0); cyc("wrap_single",    1, 1,15, 0,0, 1);

      // Flush with a concurrent commit
      rst_cyc("reset3");
      dec(1,1,5, 1,1,5); cyc("fl_alloc_a",     1, 1,1, 1,2, 63);
      dec(1,1,6, 1,1,7); cyc("fl_alloc_b",     1, 1,3, 1,4, 61);
      cmt(1,1,0, 1,0,5); cyc("fl_commit",      1, 0,0, 0,0, 59);
      dec(1,1,8, 0,0,0); cmt(1,1,1, 0,0,0); flush = 1'b1;
      cyc("flush",                             0, 0,0, 0,0, 59);
      dec(1,1,9, 1,1,10); cyc("after_flush",   1, 1,3, 1,4, 62);
      cyc("final_fc",                          1, 0,0, 0,0, 60);

      @(negedge clk); #1;
      n_checks++;
      if (q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
